// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
// Groups the alarm controller's front-panel and time-base signals.
//   one_sec_tick, eq, alarm_en, stop_alarm, snooze : into the sequencer
//   alarm_light, buzzer, snooze_active,
//   snooze_count[3:0], missed                      : out of the sequencer
// master: the side that drives the requests (time base / buttons).
// slave : the sequencer itself.
interface alarm_sequencer_if;
  logic       one_sec_tick;
  logic       eq;
  logic       alarm_en;
  logic       stop_alarm;
  logic       snooze;
  logic       alarm_light;
  logic       buzzer;
  logic       snooze_active;
  logic [3:0] snooze_count;
  logic       missed;

  modport master (
    output one_sec_tick, eq, alarm_en, stop_alarm, snooze,
    input  alarm_light, buzzer, snooze_active, snooze_count, missed
  );

  modport slave (
    input  one_sec_tick, eq, alarm_en, stop_alarm, snooze,
    output alarm_light, buzzer, snooze_active, snooze_count, missed
  );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// Sequences the alarm light and buzzer through ring, snooze and lockout
// phases, with timeouts counted in one_sec_tick pulses.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : alarm_sequencer_if.slave
//             in : one_sec_tick, eq, alarm_en, stop_alarm, snooze
//             out: alarm_light, buzzer, snooze_active, snooze_count, missed
// All outputs come straight from registers.
module alarm_sequencer #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  alarm_sequencer_if.slave    bus
);

  localparam logic [15:0] RING_LOAD   = 16'(RING_SEC);
  localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SEC);
  localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RING    = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [3:0]  count_reg, count_next;
  logic        buzzer_reg, buzzer_next;
  logic        missed_reg, missed_next;
  logic        light_reg, active_reg;

  // A tick with the timer at 1 is the last second of the phase.
  logic expire;
  assign expire = bus.one_sec_tick && (timer_reg == 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      timer_reg  <= 16'd0;
      count_reg  <= 4'd0;
      buzzer_reg <= 1'b0;
      missed_reg <= 1'b0;
      light_reg  <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      count_reg  <= count_next;
      buzzer_reg <= buzzer_next;
      missed_reg <= missed_next;
      // Indicator flags are registered copies of the next state so they
      // change on the same edge as the state itself.
      light_reg  <= (state_next == RING);
      active_reg <= (state_next == SNOOZE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = 16'd0;
    count_next  = count_reg;
    buzzer_next = 1'b0;
    missed_next = missed_reg;

    if (!bus.alarm_en) begin
      state_next  = IDLE;
      count_next  = 4'd0;
      missed_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.eq) begin
            state_next  = RING;
            timer_next  = RING_LOAD;
            count_next  = 4'd0;
            buzzer_next = 1'b1;
          end
        end

        RING: begin
          if (bus.stop_alarm) begin
            state_next  = LOCKOUT;
            missed_next = 1'b0;
          end else if (bus.snooze && (count_reg < SNOOZE_MAX)) begin
            state_next = SNOOZE;
            timer_next = SNOOZE_LOAD;
            count_next = count_reg + 4'd1;
          end else if (expire) begin
            state_next  = LOCKOUT;
            missed_next = 1'b1;
          end else begin
            timer_next  = timer_reg;
            buzzer_next = buzzer_reg;
            if (bus.one_sec_tick) begin
              // Guarded decrement: the timer never wraps below zero.
              if (timer_reg != 16'd0) timer_next = timer_reg - 16'd1;
              buzzer_next = ~buzzer_reg;
            end
          end
        end

        SNOOZE: begin
          if (bus.stop_alarm) begin
            state_next  = LOCKOUT;
            missed_next = 1'b0;
          end else if (expire) begin
            // Re-ring regardless of eq; the minute may already be over.
            state_next  = RING;
            timer_next  = RING_LOAD;
            buzzer_next = 1'b1;
          end else begin
            timer_next = timer_reg;
            if (bus.one_sec_tick && (timer_reg != 16'd0))
              timer_next = timer_reg - 16'd1;
          end
        end

        LOCKOUT: begin
          // Stay here until the matching minute ends to avoid a retrigger.
          if (!bus.eq) state_next = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.alarm_light   = light_reg;
  assign bus.buzzer        = buzzer_reg;
  assign bus.snooze_active = active_reg;
  assign bus.snooze_count  = count_reg;
  assign bus.missed        = missed_reg;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
// Directed, table-driven bench for alarm_sequencer with SNOOZE_SEC=3,
// RING_SEC=4, MAX_SNOOZE=2 and ticks spaced 10 cycles apart. Each table
// record holds a count of quiet cycles, one cycle of inputs and the
// expected outputs after that cycle's edge. Reset behaviour is checked
// by hand-written sequences.
module tb_alarm_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .SNOOZE_SEC (3),
    .RING_SEC   (4),
    .MAX_SNOOZE (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    int       gap;
    bit       tick;
    bit       eq;
    bit       en;
    bit       stop;
    bit       snz;
    bit [7:0] exp;   // {light, buzzer, snooze_active, count[3:0], missed}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input int gap,
                     input bit tick, input bit eq, input bit en,
                     input bit stop, input bit snz,
                     input bit l, input bit b, input bit s,
                     input bit [3:0] c, input bit m);
    vec_t v;
    v.name = name; v.gap = gap; v.tick = tick; v.eq = eq; v.en = en;
    v.stop = stop; v.snz = snz; v.exp = {l, b, s, c, m};
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] outs();
    return {bus.alarm_light, bus.buzzer, bus.snooze_active,
            bus.snooze_count, bus.missed};
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got L,B,S,C,M=%b,%b,%b,%0d,%b required %b,%b,%b,%0d,%b",
               name, act[7], act[6], act[5], act[4:1], act[0],
               exp[7], exp[6], exp[5], exp[4:1], exp[0]);
    end else begin
      $display("ok   %s: L,B,S,C,M=%b,%b,%b,%0d,%b",
               name, act[7], act[6], act[5], act[4:1], act[0]);
    end
  endtask

  // One clock cycle: drive on the falling edge, let the rising edge pass.
  task automatic cyc(input bit tick, input bit eq, input bit en,
                     input bit stop, input bit snz);
    @(negedge clk);
    bus.one_sec_tick = tick;
    bus.eq           = eq;
    bus.alarm_en     = en;
    bus.stop_alarm   = stop;
    bus.snooze       = snz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    bus.one_sec_tick = 1'b0;
    bus.eq           = 1'b0;
    bus.alarm_en     = 1'b0;
    bus.stop_alarm   = 1'b0;
    bus.snooze       = 1'b0;
    reset            = 1'b1;
    #1;
    check("reset_async", outs(), 8'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", outs(), 8'b0);
    @(negedge clk);
    reset = 1'b0;

    //    name                gap tk eq en st sn   L  B  S  C  M
    // Basic ring, timeout, lockout
    add("idle",               0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    add("ring_entry",         0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("ring_tick1",         9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    add("ring_tick2",         9, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("ring_tick3",         9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    add("ring_timeout",       9, 1, 1, 1, 0, 0,   0, 0, 0, 0, 1);
    add("lockout_hold",       5, 0, 1, 1, 0, 0,   0, 0, 0, 0, 1);
    add("lockout_tick",       9, 1, 1, 1, 0, 0,   0, 0, 0, 0, 1);
    add("lockout_exit",       0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    add("idle_quiet",         3, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
    // Stop together with the expiry tick: stop wins, missed cleared
    add("ring2_keeps_missed", 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 1);
    add("ring2_tick1",        9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 1);
    add("ring2_tick2",        9, 1, 1, 1, 0, 0,   1, 1, 0, 0, 1);
    add("ring2_tick3",        9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 1);
    add("stop_at_expiry",     9, 1, 1, 1, 1, 0,   0, 0, 0, 0, 0);
    add("exit2",              0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    // Snooze cycle up to the limit
    add("ring3",              0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("snooze1",            2, 0, 1, 1, 0, 1,   0, 0, 1, 1, 0);
    add("snz_tick1_snz_ign",  9, 1, 1, 1, 0, 1,   0, 0, 1, 1, 0);
    add("snz_tick2",          9, 1, 1, 1, 0, 0,   0, 0, 1, 1, 0);
    add("rering1",            9, 1, 1, 1, 0, 0,   1, 1, 0, 1, 0);
    add("snooze2",            2, 0, 1, 1, 0, 1,   0, 0, 1, 2, 0);
    add("snz2_tick1",         9, 1, 1, 1, 0, 0,   0, 0, 1, 2, 0);
    add("snz2_tick2",         9, 1, 1, 1, 0, 0,   0, 0, 1, 2, 0);
    add("rering2",            9, 1, 1, 1, 0, 0,   1, 1, 0, 2, 0);
    add("snooze3_ignored",    2, 0, 1, 1, 0, 1,   1, 1, 0, 2, 0);
    add("rering2_tick1",      9, 1, 1, 1, 0, 0,   1, 0, 0, 2, 0);
    add("stop_and_snooze",    0, 0, 1, 1, 1, 1,   0, 0, 0, 2, 0);
    add("exit3",              0, 0, 0, 1, 0, 0,   0, 0, 0, 2, 0);
    // Snooze together with the expiry tick: snooze wins
    add("ring4_clears_count", 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("ring4_tick1",        9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    add("ring4_tick2",        9, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("ring4_tick3",        9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    add("snooze_at_expiry",   9, 1, 1, 1, 0, 1,   0, 0, 1, 1, 0);
    // Disarm during snooze
    add("disarm",             4, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add("disarm_tick1",       9, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add("disarm_tick2",       9, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add("disarm_tick3",       9, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add("rearm_eq_high",      0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("ring5_tick1",        9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    add("ring5_tick2",        9, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0);
    add("ring5_tick3",        9, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0);
    add("ring5_timeout",      9, 1, 1, 1, 0, 0,   0, 0, 0, 0, 1);
    add("disarm_clr_missed",  0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
    add("idle_end",           0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      for (int g = 0; g < vecs[i].gap; g++)
        cyc(1'b0, vecs[i].eq, vecs[i].en, 1'b0, 1'b0);
      cyc(vecs[i].tick, vecs[i].eq, vecs[i].en, vecs[i].stop, vecs[i].snz);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Asynchronous reset while ringing (after one snooze so count is 1)
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hr_ring", outs(), {1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      for (int g = 0; g < 9; g++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("hr_rering", outs(), {1'b1, 1'b1, 1'b0, 4'd1, 1'b0});
    #2;
    reset = 1'b1;
    #1;
    check("hr_reset_midcycle", outs(), 8'b0);
    @(posedge clk);
    #1;
    check("hr_reset_over_edge", outs(), 8'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("hr_released_no_edge", outs(), 8'b0);
    @(posedge clk);
    #1;
    check("hr_reenter_ring", outs(), {1'b1, 1'b1, 1'b0, 4'd0, 1'b0});
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("hr_stop", outs(), 8'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Controller that sequences the alarm-light path of the digital clock. It watches the time-equals-alarm comparator output and the user buttons, then drives the alarm light and buzzer through ring, snooze and lockout phases with second-accurate timeouts. It sits between the alarm comparator and time base (`eq`, `one_sec_tick`) and the front-panel indicators, and replaces direct use of the latched light for user-facing alarm behaviour.

## Interface
- `SNOOZE_SEC`, default 300: seconds spent in snooze before re-ringing; legal range 1..65535.
- `RING_SEC`, default 60: seconds the alarm rings before auto-stopping; legal range 1..65535.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; legal range 0..15.

Ports (name, direction, width, meaning):
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces every register to its reset value.
- `one_sec_tick` input 1: single-cycle pulse, once per second.
- `eq` input 1: current time equals alarm time; level, high for a whole minute.
- `alarm_en` input 1: alarm armed.
- `stop_alarm` input 1: stop request, single-cycle pulse (debounced upstream).
- `snooze` input 1: snooze request, single-cycle pulse.
- `alarm_light` output 1: high while ringing.
- `buzzer` output 1: toggles on each tick while ringing, low otherwise.
- `snooze_active` output 1: high in SNOOZE.
- `snooze_count` output 4: snoozes used in the current event.
- `missed` output 1: sticky flag, set when a ring times out.

## Operation
- State machine with four states: IDLE, RING, SNOOZE, LOCKOUT. All outputs are registered (Moore).
- Reset values: state IDLE; all outputs 0; timer 0.
- `alarm_en` = 0 has top priority. From any state, go to IDLE and clear `snooze_count` and `missed`.
- IDLE → RING when `eq` = 1. Load timer with RING_SEC and clear `snooze_count`. `missed` is kept.
- RING, priority order:
  1. `stop_alarm`: go to LOCKOUT and clear `missed`.
  2. `snooze` with `snooze_count` < MAX_SNOOZE: go to SNOOZE, load timer with SNOOZE_SEC, increment `snooze_count`.
  3. Timer expiry: go to LOCKOUT and set `missed`.
- A `snooze` in RING with `snooze_count` = MAX_SNOOZE is ignored; the state stays RING.
- SNOOZE:
  - `stop_alarm`: go to LOCKOUT and clear `missed`.
  - Timer expiry: go to RING and load timer with RING_SEC.
  - `snooze` is ignored.
- LOCKOUT → IDLE when `eq` = 0. This prevents a retrigger within the same matching minute.
- Timer rule: loaded with N on state entry. Decremented on each `one_sec_tick` while in RING or SNOOZE. Expiry is a tick arriving while the timer = 1. So exactly N ticks elapse in the state, and the transition happens on that tick's edge.
- Timer is 16 bits wide and never wraps. It holds at 0 outside RING and SNOOZE.
- `buzzer`:
  - Set to 1 on RING entry.
  - Inverted on each tick in RING.
  - Forced to 0 in every other state.
- `alarm_light` = 1 exactly when the state is RING. `snooze_active` = 1 exactly when the state is SNOOZE.

## Timing
- `eq` rising in IDLE with `alarm_en` = 1: `alarm_light` goes high one clock later (the edge after sampling). Latency is 1 cycle.
- A `stop_alarm` or `snooze` pulse sampled on edge k: outputs reflect the new state after edge k.
- Simultaneous `stop_alarm` and `snooze` in RING: stop wins.
- Simultaneous `stop_alarm` and expiry tick: stop wins, and `missed` stays cleared.
- Simultaneous `snooze` and expiry tick in RING with snooze allowed: snooze wins, and `missed` is not set.
- `eq` still high on SNOOZE expiry: re-ring as normal. RING is entered from SNOOZE regardless of `eq`.
- `reset` asserted mid-ring: `alarm_light` and `buzzer` drop asynchronously with no clock edge needed. After release, a still-high `eq` re-enters RING on the next edge.
- `alarm_en` falling mid-SNOOZE: go to IDLE on the next edge and clear `snooze_count`.

## Test plan
All scenarios use SNOOZE_SEC=3, RING_SEC=4, MAX_SNOOZE=2, with ticks every 10 cycles.
- Basic ring: `alarm_en`=1, raise `eq` → `alarm_light`=1 one cycle later. `buzzer` = 1,0,1,0 across ticks. After the 4th tick the state is LOCKOUT, `missed`=1, `alarm_light`=0. Drop `eq` → IDLE.
- Snooze cycle: ring, pulse `snooze` → `snooze_active`=1 and `snooze_count`=1. Exactly 3 ticks later, `alarm_light`=1 again. A second snooze gives `snooze_count`=2. A third snooze is ignored and `alarm_light` stays 1.
- Stop and lockout: ring with `eq` held high, pulse `stop_alarm` → `alarm_light`=0, `missed`=0. The state stays LOCKOUT for as long as `eq`=1, and `alarm_light` must not retrigger.
- Simultaneous events: in RING, pulse `stop_alarm` and `snooze` in the same cycle → LOCKOUT, `snooze_count` unchanged. Drive `snooze` together with the 4th tick → SNOOZE, `missed`=0.
- Async reset: assert `reset` between clock edges while ringing → all outputs 0 immediately. Release with `eq`=1 → `alarm_light`=1 one edge later.
- Disarm: `alarm_en`=0 during SNOOZE with `snooze_count`=1 → IDLE next edge, `snooze_count`=0, and no re-ring after 3 ticks.
